pipeline_stage_reg: RTL
=======================

# pipeline_stage_reg

Generic, parametrised pipeline stage register for the RISC-V core. It replaces the fixed-field, always-advancing inter-stage registers with a single block that carries an opaque payload and control vector under a valid/ready handshake. It supports stall (backpressure), synchronous flush (bubble insertion), and an optional 2-entry skid buffer that breaks the ready path. It sits between any two stages (IF/ID, ID/EX, EX/MEM, MEM/WB); the hazard unit drives `flush`.

## Interface
- `DATA_W`, 32: payload width (PC, operands, immediate, register indices, packed by the instantiating stage).
- `CTRL_W`, 16: control-vector width (RegWrite, MemWrite, Branch, ...); all-zero encodes a NOP.
- `RESET_VAL`, 0: reset value of the `out_data` register.
- `SKID`, 1: 1 means 2-entry skid buffer with registered `in_ready`; 0 means single register with combinational `in_ready`.
- `CNT_W`, 16: stall-counter width.

- `clk`  in  1  clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `flush`  in  1  synchronous kill of all held entries.
- `in_valid`  in  1  upstream entry valid.
- `in_ready`  out  1  stage can accept an entry.
- `in_data`  in  DATA_W  upstream payload.
- `in_ctrl`  in  CTRL_W  upstream control vector.
- `out_valid`  out  1  downstream entry valid.
- `out_ready`  in  1  downstream accepts.
- `out_data`  out  DATA_W  head-entry payload.
- `out_ctrl`  out  CTRL_W  head-entry control; forced to 0 whenever `out_valid`=0.
- `stall_count`  out  CNT_W  saturating count of cycles with `out_valid`=1 and `out_ready`=0.

## Operation
- Accept = `in_valid & in_ready`. Issue = `out_valid & out_ready`.
- States are EMPTY, ONE (main register full), and TWO (main and skid both full; reachable only when SKID=1).
- EMPTY: on accept, main is loaded and the state goes to ONE.
- ONE:
  - Accept and issue: main is reloaded and the state stays ONE.
  - Accept without issue: skid is loaded and the state goes to TWO.
  - Issue only: the state goes to EMPTY.
- TWO: on issue, main is loaded from skid and the state goes to ONE. No accept is possible in TWO.
- Entries leave in strict FIFO order.
- `in_ready`:
  - SKID=1: `!reset && state!=TWO`. This depends only on registered state and `reset`.
  - SKID=0: `!reset && (!out_valid || out_ready)`.
- Flush has the highest priority.
  - Next state is EMPTY; main and skid ctrl are cleared to 0; data registers hold their values.
  - An entry accepted in the flush cycle is discarded. The upstream sees a completed handshake.
- `stall_count` increments each stalled cycle and saturates at 2^CNT_W−1. Flush does not clear it; only `reset` does.
- Reset (asynchronous, any state, including mid-transfer):
  - state=EMPTY, `out_valid`=0, `out_ctrl`=0, `out_data`=RESET_VAL.
  - skid contents are zero; `stall_count`=0; `in_ready`=0 while `reset` is high.

## Timing
- Latency: 1 cycle. An entry accepted at edge N is visible on `out_*` after edge N.
- Throughput: 1 entry per cycle while `out_ready` is held high, for both SKID values.
- SKID=1: no combinational path from `out_ready` to `in_ready`. `in_ready` falls the cycle after the second unissued accept.
- SKID=0: `in_ready` follows `out_ready` within the same cycle.
- Flush asserted at edge N: `out_valid`=0 and `out_ctrl`=0 after edge N. `in_ready`=1 in the following cycle (unless `reset` is high).
- Simultaneous flush and reset: reset wins.
- Simultaneous accept and issue in ONE: no bubble, state remains ONE.

## Structure
- Package `pipe_pkg` holds:
  - the state typedef: EMPTY=2'b00, ONE=2'b01, TWO=2'b10;
  - the NOP control constant, all-zero of CTRL_W.
- Sub-module `pipe_sat_counter` (parameter W; ports inc, value) implements `stall_count`.
- The handshake FSM and the data/skid registers stay in `pipeline_stage_reg`.

## Test plan
- **Reset mid-stream:** SKID=1, reach TWO, raise `reset` between edges → `out_valid`=0, `out_ctrl`=0, `out_data`=0, `stall_count`=0 immediately with no clock, `in_ready`=0; after release and one edge, `in_ready`=1.
- **Streaming:** DATA_W=32, `out_ready`=1, push 0x11, 0x22, 0x33 back-to-back → outputs 0x11, 0x22, 0x33 on consecutive cycles starting 1 cycle later; `stall_count`=0.
- **Backpressure, SKID=1:** `out_ready`=0, push A, B → state TWO and `in_ready`=0; hold C valid for 3 cycles, then raise `out_ready` → outputs A, B, C in order, no loss or duplication; `stall_count` equals the stalled cycles counted.
- **Flush:** in TWO with `in_valid`=1 carrying D, assert `flush` for one cycle → next cycle `out_valid`=0, `out_ctrl`=0, `in_ready`=1; A, B, D never appear on the output.
- **SKID=0:** `out_valid`=1 and `out_ready`=0 → `in_ready`=0 in the same cycle; raise `out_ready` → `in_ready`=1 in the same cycle; an accept and an issue in the same cycle give a new `out_data` after the edge.
- **Saturation:** CNT_W=4, hold `out_valid`=1 and `out_ready`=0 for 20 cycles → `stall_count`=15 and stays there; apply `flush` → still 15.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline stage register.
package pipe_pkg;

    // Occupancy of the stage: nothing held, main register held, main and skid held.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        TWO   = 2'b10
    } state_t;

    // Upper bound on the control-vector width that NOP_CTRL can be sliced to.
    localparam int CTRL_W_MAX = 1024;

    // All-zero control vector: a bubble that does nothing in any stage.
    localparam logic [CTRL_W_MAX-1:0] NOP_CTRL = '0;

    // A stalled cycle is one where the head entry is valid but not taken.
    function automatic logic stall_cond(input logic valid, input logic ready);
        return valid & ~ready;
    endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter; sticks at all-ones and is cleared only by reset.
module pipe_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] value
);

    logic [W-1:0] value_q;
    logic [W-1:0] value_d;

    // Next count: add one unless already saturated.
    always_comb begin
        value_d = value_q;
        if (inc && (value_q != {W{1'b1}})) begin
            value_d = value_q + {{(W-1){1'b0}}, 1'b1};
        end else begin
            value_d = value_q;
        end
    end

    // Count register with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/pipeline_stage_reg.sv
// Valid/ready pipeline stage register with optional 2-entry skid buffer,
// synchronous flush and a saturating stall counter.
module pipeline_stage_reg #(
    parameter int                DATA_W    = 32,
    parameter int                CTRL_W    = 16,
    parameter logic [DATA_W-1:0] RESET_VAL = '0,
    parameter int                SKID      = 1,
    parameter int                CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_count
);

    import pipe_pkg::*;

    localparam logic [CTRL_W-1:0] NOP     = NOP_CTRL[CTRL_W-1:0];
    localparam logic              SKID_EN = (SKID != 0);

    state_t             state_q;
    state_t             state_d;
    logic [DATA_W-1:0]  main_data_q;
    logic [DATA_W-1:0]  main_data_d;
    logic [CTRL_W-1:0]  main_ctrl_q;
    logic [CTRL_W-1:0]  main_ctrl_d;
    logic [DATA_W-1:0]  skid_data_q;
    logic [DATA_W-1:0]  skid_data_d;
    logic [CTRL_W-1:0]  skid_ctrl_q;
    logic [CTRL_W-1:0]  skid_ctrl_d;
    logic               accept_s;
    logic               issue_s;

    assign out_valid = (state_q != EMPTY);
    assign accept_s  = in_valid & in_ready;
    assign issue_s   = out_valid & out_ready;

    // main_ctrl_q is cleared whenever the stage empties, so the head control
    // is already a NOP while out_valid is low and can be driven straight out.
    assign out_data  = main_data_q;
    assign out_ctrl  = main_ctrl_q;

    generate
        if (SKID != 0) begin : g_skid_ready
            // Registered-state only: breaks the out_ready -> in_ready path.
            assign in_ready = !reset && (state_q != TWO);
        end else begin : g_pass_ready
            assign in_ready = !reset && (!out_valid || out_ready);
        end
    endgenerate

    // Handshake FSM next state and register loads; flush overrides everything.
    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;
        if (flush) begin
            state_d     = EMPTY;
            main_ctrl_d = NOP;
            skid_ctrl_d = NOP;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept_s) begin
                        main_data_d = in_data;
                        main_ctrl_d = in_ctrl;
                        state_d     = ONE;
                    end else begin
                        state_d = EMPTY;
                    end
                end
                ONE: begin
                    if (accept_s && issue_s) begin
                        main_data_d = in_data;
                        main_ctrl_d = in_ctrl;
                        state_d     = ONE;
                    end else if (accept_s && SKID_EN) begin
                        skid_data_d = in_data;
                        skid_ctrl_d = in_ctrl;
                        state_d     = TWO;
                    end else if (issue_s) begin
                        main_ctrl_d = NOP;
                        state_d     = EMPTY;
                    end else begin
                        state_d = ONE;
                    end
                end
                TWO: begin
                    if (issue_s) begin
                        main_data_d = skid_data_q;
                        main_ctrl_d = skid_ctrl_q;
                        skid_ctrl_d = NOP;
                        state_d     = ONE;
                    end else begin
                        state_d = TWO;
                    end
                end
                default: begin
                    state_d     = EMPTY;
                    main_ctrl_d = NOP;
                    skid_ctrl_d = NOP;
                end
            endcase
        end
    end

    // State, main and skid registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= EMPTY;
            main_data_q <= RESET_VAL;
            main_ctrl_q <= NOP;
            skid_data_q <= '0;
            skid_ctrl_q <= NOP;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
        end
    end

    pipe_sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_cond(out_valid, out_ready)),
        .value (stall_count)
    );

endmodule
